// File: rtl/snake_body_pkg.sv
// rtl/snake_body_pkg.sv - shared game state codes, start position and size defaults for snake_body
//
// Purpose : common definitions for the snake body block and its neighbours.
// Contents: main_state_e  - main FSM state codes (MAIN_WAIT, MAIN_GAME1..3)
//           INITIAL_X/Y   - head position after reset / MAIN_WAIT reload
//           SNAKE_MAX_LEN - default segment array depth
//           SNAKE_INIT_LEN- default length after reset
//           is_game_state - true for the three in-game states
package snake_body_pkg;

    typedef enum logic [2:0] {
        MAIN_WAIT  = 3'd0,
        MAIN_GAME1 = 3'd1,
        MAIN_GAME2 = 3'd2,
        MAIN_GAME3 = 3'd3
    } main_state_e;

    localparam int INITIAL_X      = 8;
    localparam int INITIAL_Y      = 8;
    localparam int SNAKE_MAX_LEN  = 32;
    localparam int SNAKE_INIT_LEN = 3;

    function automatic logic is_game_state(input logic [2:0] st);
        return (st == MAIN_GAME1) || (st == MAIN_GAME2) || (st == MAIN_GAME3);
    endfunction

endpackage

// File: rtl/snake_body_if.sv
// rtl/snake_body_if.sv - control, head and query signal bundle between snake_body and its neighbours
//
// Purpose : groups every non-clock/reset signal of snake_body.
// Modports: master - game logic / renderer side (drives state, move, grow, query)
//           slave  - snake_body side (drives head, length, full, collide, query result)
// Signals : state, move_tick, head_next_x/y, grow, query_x/y          (master -> slave)
//           head_x/y, length, full, collide, query_hit, query_is_head (slave -> master)
interface snake_body_if #(
    parameter int COORD_W = 5,
    parameter int LEN_W   = 6
);
    logic [2:0]         state;
    logic               move_tick;
    logic [COORD_W-1:0] head_next_x;
    logic [COORD_W-1:0] head_next_y;
    logic               grow;
    logic [COORD_W-1:0] query_x;
    logic [COORD_W-1:0] query_y;
    logic [COORD_W-1:0] head_x;
    logic [COORD_W-1:0] head_y;
    logic [LEN_W-1:0]   length;
    logic               full;
    logic               collide;
    logic               query_hit;
    logic               query_is_head;

    modport master (
        output state, move_tick, head_next_x, head_next_y, grow, query_x, query_y,
        input  head_x, head_y, length, full, collide, query_hit, query_is_head
    );

    modport slave (
        input  state, move_tick, head_next_x, head_next_y, grow, query_x, query_y,
        output head_x, head_y, length, full, collide, query_hit, query_is_head
    );
endinterface

// File: rtl/snake_seg_match.sv
// rtl/snake_seg_match.sv - per-segment coordinate comparator against one target cell
//
// Purpose : flags every enabled segment whose packed {x,y} equals the target.
// Ports   : i_segs   - packed segment array, entry 0 is the head
//           i_mask   - per-segment enable (only enabled entries may match)
//           i_target - packed {x,y} cell to look for
//           o_match  - one bit per segment
module snake_seg_match #(
    parameter int N = 32,
    parameter int W = 10
) (
    input  logic [N-1:0][W-1:0] i_segs,
    input  logic [N-1:0]        i_mask,
    input  logic [W-1:0]        i_target,
    output logic [N-1:0]        o_match
);
    always_comb begin
        o_match = '0;
        for (int i = 0; i < N; i++) begin
            o_match[i] = i_mask[i] && (i_segs[i] == i_target);
        end
    end
endmodule

// File: rtl/snake_body.sv
// rtl/snake_body.sv - snake segment array with growth, self-collision and cell occupancy query
//
// Purpose : captures the next head on each move tick, shifts the body, tracks
//           length/growth, flags self-collision and answers renderer queries.
// Ports   : clk   - system clock
//           rst_n - asynchronous active-low reset
//           bus   - snake_body_if.slave (state, move_tick, head_next_x/y, grow,
//                   query_x/y in; head_x/y, length, full, collide,
//                   query_hit, query_is_head out)
// Options : SNAKE_SELF_COLLIDE_EN - builds the collision comparator; when
//           undefined, collide is tied to 0.
module snake_body
    import snake_body_pkg::*;
#(
    parameter int MAX_LEN  = SNAKE_MAX_LEN,
    parameter int INIT_LEN = SNAKE_INIT_LEN,
    parameter int COORD_W  = 5
) (
    input logic         clk,
    input logic         rst_n,
    snake_body_if.slave bus
);
    localparam int LEN_W = $clog2(MAX_LEN) + 1;
    localparam int SEG_W = 2 * COORD_W;

    typedef logic [MAX_LEN-1:0][SEG_W-1:0] seg_arr_t;

    // Start layout: head at the initial position, body trailing to the left.
    function automatic seg_arr_t init_segs();
        seg_arr_t s;
        s = '0;
        for (int i = 0; i < INIT_LEN; i++) begin
            s[i] = {COORD_W'(INITIAL_X - i), COORD_W'(INITIAL_Y)};
        end
        return s;
    endfunction

    seg_arr_t           r_seg;
    logic [LEN_W-1:0]   r_len;
    logic               r_pending_grow;
    logic               r_collide;
    logic               r_query_hit;
    logic               r_query_is_head;

    logic               w_game;
    logic               w_grow_now;
    logic               w_hit_body;
    logic [SEG_W-1:0]   w_head_next;
    logic [SEG_W-1:0]   w_query;
    logic [MAX_LEN-1:0] w_valid;
    logic [MAX_LEN-1:0] w_qmatch;

    assign w_game      = is_game_state(bus.state);
    assign w_head_next = {bus.head_next_x, bus.head_next_y};
    assign w_query     = {bus.query_x, bus.query_y};
    // A grow arriving on the tick itself counts; at full length it is dropped.
    assign w_grow_now  = (r_pending_grow | bus.grow) && (r_len < LEN_W'(MAX_LEN));

    always_comb begin
        w_valid = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            w_valid[i] = (LEN_W'(i) < r_len);
        end
    end

    snake_seg_match #(.N(MAX_LEN), .W(SEG_W)) u_query_match (
        .i_segs   (r_seg),
        .i_mask   (w_valid),
        .i_target (w_query),
        .o_match  (w_qmatch)
    );

`ifdef SNAKE_SELF_COLLIDE_EN
    logic [LEN_W-1:0]   w_cmp_len;
    logic [MAX_LEN-1:0] w_cmask;
    logic [MAX_LEN-1:0] w_cmatch;

    // A non-growing tail vacates its cell on this move, so it is left out.
    assign w_cmp_len = w_grow_now ? r_len : r_len - LEN_W'(1);

    always_comb begin
        w_cmask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            w_cmask[i] = (LEN_W'(i) < w_cmp_len);
        end
    end

    snake_seg_match #(.N(MAX_LEN), .W(SEG_W)) u_collide_match (
        .i_segs   (r_seg),
        .i_mask   (w_cmask),
        .i_target (w_head_next),
        .o_match  (w_cmatch)
    );

    assign w_hit_body = |w_cmatch;
`else
    assign w_hit_body = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg           <= init_segs();
            r_len           <= LEN_W'(INIT_LEN);
            r_pending_grow  <= 1'b0;
            r_collide       <= 1'b0;
            r_query_hit     <= 1'b0;
            r_query_is_head <= 1'b0;
        end else begin
            // Query sees the array as it was before this cycle's update.
            r_query_hit     <= |w_qmatch;
            r_query_is_head <= w_qmatch[0];
            r_collide       <= 1'b0;
            if (bus.state == MAIN_WAIT) begin
                r_seg          <= init_segs();
                r_len          <= LEN_W'(INIT_LEN);
                r_pending_grow <= 1'b0;
            end else if (w_game) begin
                if (bus.move_tick) begin
                    r_seg          <= {r_seg[MAX_LEN-2:0], w_head_next};
                    r_pending_grow <= 1'b0;
                    r_collide      <= w_hit_body;
                    if (w_grow_now) begin
                        r_len <= r_len + LEN_W'(1);
                    end
                end else if (bus.grow) begin
                    r_pending_grow <= 1'b1;
                end
            end
        end
    end

    assign bus.head_x        = r_seg[0][SEG_W-1:COORD_W];
    assign bus.head_y        = r_seg[0][COORD_W-1:0];
    assign bus.length        = r_len;
    assign bus.full          = (r_len == LEN_W'(MAX_LEN));
    assign bus.collide       = r_collide;
    assign bus.query_hit     = r_query_hit;
    assign bus.query_is_head = r_query_is_head;

endmodule

// File: tb/tb_snake_body.sv
// tb/tb_snake_body.sv - self-checking bench for snake_body
module tb_snake_body;
    import snake_body_pkg::*;

`ifdef SNAKE_SELF_COLLIDE_EN
    localparam bit COL_EN = 1'b1;
`else
    localparam bit COL_EN = 1'b0;
`endif

    typedef struct {
        string      name;
        logic [4:0] hx;
        logic [4:0] hy;
        logic [5:0] len;
        logic       full;
        logic       col;
        logic       hit;
        logic       ishead;
    } exp_t;

    typedef struct {
        logic [2:0] st;
        logic       tk;
        logic       gr;
        int         nx, ny, qx, qy;
        exp_t       e;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;
    exp_t sb_q[$];
    vec_t tbl[22];

    always #5 clk = ~clk;

    snake_body_if #(.COORD_W(5), .LEN_W(6)) bus ();

    snake_body #(.MAX_LEN(32), .INIT_LEN(3), .COORD_W(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    function automatic exp_t mk(string n, int hx, int hy, int len, bit full, bit col, bit hit, bit ish);
        exp_t e;
        e.name = n; e.hx = 5'(hx); e.hy = 5'(hy); e.len = 6'(len);
        e.full = full; e.col = col; e.hit = hit; e.ishead = ish;
        return e;
    endfunction

    function automatic vec_t mkv(logic [2:0] st, bit tk, bit gr, int nx, int ny, int qx, int qy, exp_t e);
        vec_t v;
        v.st = st; v.tk = tk; v.gr = gr; v.nx = nx; v.ny = ny; v.qx = qx; v.qy = qy; v.e = e;
        return v;
    endfunction

    task automatic check_now(input exp_t e);
        n_vec++;
        if ({bus.head_x, bus.head_y, bus.length, bus.full, bus.collide, bus.query_hit, bus.query_is_head} !==
            {e.hx, e.hy, e.len, e.full, e.col, e.hit, e.ishead}) begin
            n_err++;
            $display("FAIL %s: got hx=%0d hy=%0d len=%0d full=%0b col=%0b hit=%0b head=%0b, expected hx=%0d hy=%0d len=%0d full=%0b col=%0b hit=%0b head=%0b",
                     e.name, bus.head_x, bus.head_y, bus.length, bus.full, bus.collide, bus.query_hit,
                     bus.query_is_head, e.hx, e.hy, e.len, e.full, e.col, e.hit, e.ishead);
        end
    endtask

    // Drive one cycle of inputs at the negedge, push the expectation, compare at the next negedge.
    task automatic step(input logic [2:0] st, input bit tk, input bit gr, input int nx, input int ny,
                        input int qx, input int qy, input exp_t e);
        bus.state       = st;
        bus.move_tick   = tk;
        bus.grow        = gr;
        bus.head_next_x = 5'(nx);
        bus.head_next_y = 5'(ny);
        bus.query_x     = 5'(qx);
        bus.query_y     = 5'(qy);
        sb_q.push_back(e);
        @(negedge clk);
        if (sb_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL scoreboard_empty: got 0 entries, expected 1");
        end else begin
            check_now(sb_q.pop_front());
        end
    endtask

    // Assert reset away from any clock edge and check that it acts immediately.
    task automatic do_reset(input string n);
        bus.state = MAIN_WAIT; bus.move_tick = 1'b0; bus.grow = 1'b0;
        bus.query_x = 5'd31; bus.query_y = 5'd31;
        #2 rst_n = 1'b0;
        #1 check_now(mk(n, 8, 8, 3, 0, 0, 0, 0));
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int sat_len;
        int mv_x[6], mv_y[6], mv_len[6];
        bit mv_gr[6], mv_col[6];

        tbl[0]  = mkv(MAIN_WAIT,  0, 0,  0,  0,  6,  8, mk("wait_q_seg2",        8, 8, 3, 0, 0, 1, 0));
        tbl[1]  = mkv(MAIN_WAIT,  1, 1, 20, 20,  8,  8, mk("wait_tick_ignored",  8, 8, 3, 0, 0, 1, 1));
        tbl[2]  = mkv(MAIN_GAME1, 1, 0,  9,  8,  6,  8, mk("move1",              9, 8, 3, 0, 0, 1, 0));
        tbl[3]  = mkv(MAIN_GAME1, 0, 0,  0,  0,  6,  8, mk("q_old_tail_gone",    9, 8, 3, 0, 0, 0, 0));
        tbl[4]  = mkv(MAIN_GAME1, 0, 0,  0,  0,  7,  8, mk("q_seg2_after_move",  9, 8, 3, 0, 0, 1, 0));
        tbl[5]  = mkv(MAIN_GAME1, 0, 1,  0,  0,  9,  8, mk("grow_pulse",         9, 8, 3, 0, 0, 1, 1));
        tbl[6]  = mkv(MAIN_GAME1, 0, 0,  0,  0, 31, 31, mk("idle1",              9, 8, 3, 0, 0, 0, 0));
        tbl[7]  = mkv(MAIN_GAME1, 0, 0,  0,  0, 31, 31, mk("idle2",              9, 8, 3, 0, 0, 0, 0));
        tbl[8]  = mkv(MAIN_GAME1, 1, 0, 10,  8,  7,  8, mk("pending_grow_move", 10, 8, 4, 0, 0, 1, 0));
        tbl[9]  = mkv(MAIN_GAME1, 0, 0,  0,  0,  7,  8, mk("q_new_tail",        10, 8, 4, 0, 0, 1, 0));
        tbl[10] = mkv(MAIN_GAME2, 1, 0, 11,  8,  7,  8, mk("move_game2",        11, 8, 4, 0, 0, 1, 0));
        tbl[11] = mkv(MAIN_GAME2, 0, 0,  0,  0,  7,  8, mk("q_invalid_seg",     11, 8, 4, 0, 0, 0, 0));
        tbl[12] = mkv(3'd4,       1, 1,  0,  0, 11,  8, mk("other_state_hold",  11, 8, 4, 0, 0, 1, 1));
        tbl[13] = mkv(MAIN_GAME3, 1, 0, 12,  8,  8,  8, mk("move_game3",        12, 8, 4, 0, 0, 1, 0));
        tbl[14] = mkv(MAIN_GAME3, 1, 1, 13,  8,  8,  8, mk("grow_with_tick",    13, 8, 5, 0, 0, 0, 0));
        tbl[15] = mkv(MAIN_GAME3, 0, 1,  0,  0, 31, 31, mk("grow_a",            13, 8, 5, 0, 0, 0, 0));
        tbl[16] = mkv(MAIN_GAME3, 0, 1,  0,  0, 31, 31, mk("grow_b",            13, 8, 5, 0, 0, 0, 0));
        tbl[17] = mkv(MAIN_GAME3, 1, 0, 14,  8, 31, 31, mk("multi_grow_once",   14, 8, 6, 0, 0, 0, 0));
        tbl[18] = mkv(MAIN_GAME3, 1, 0, 15,  8, 13,  8, mk("move_no_grow",      15, 8, 6, 0, 0, 1, 0));
        tbl[19] = mkv(MAIN_WAIT,  1, 1, 16,  8, 13,  8, mk("wait_reload",        8, 8, 3, 0, 0, 1, 0));
        tbl[20] = mkv(MAIN_WAIT,  0, 0,  0,  0,  7,  8, mk("reload_q_seg1",      8, 8, 3, 0, 0, 1, 0));
        tbl[21] = mkv(MAIN_WAIT,  0, 0,  0,  0, 15,  8, mk("reload_cleared",     8, 8, 3, 0, 0, 0, 0));

        @(negedge clk);
        do_reset("reset_async_first");

        for (int i = 0; i < 22; i++) begin
            step(tbl[i].st, tbl[i].tk, tbl[i].gr, tbl[i].nx, tbl[i].ny, tbl[i].qx, tbl[i].qy, tbl[i].e);
        end

        // Tail handling: a non-growing tail is excluded, a growing one is not.
        do_reset("reset_before_tail");
        step(MAIN_GAME1, 1, 0, 6, 8, 31, 31, mk("onto_moving_tail",  6, 8, 3, 0, 0, 0, 0));
        step(MAIN_GAME1, 1, 1, 7, 8, 31, 31, mk("onto_growing_tail", 7, 8, 4, 0, COL_EN, 0, 0));
        step(MAIN_GAME1, 0, 0, 0, 0, 31, 31, mk("collide_one_cycle", 7, 8, 4, 0, 0, 0, 0));

        // Build length 5, then run the head into seg2, then onto the moving tail.
        mv_x = '{9, 9, 8, 9, 0, 8};  mv_y = '{8, 9, 9, 8, 0, 8};
        mv_gr = '{1, 1, 0, 0, 0, 0}; mv_len = '{4, 5, 5, 5, 5, 5};
        mv_col = '{0, 0, 0, COL_EN, 0, 0};
        do_reset("reset_before_body");
        for (int i = 0; i < 6; i++) begin
            if (i == 4)
                step(MAIN_GAME1, 0, 0, 0, 0, 31, 31, mk("body_collide_clears", 9, 8, 5, 0, 0, 0, 0));
            else
                step(MAIN_GAME1, 1, mv_gr[i], mv_x[i], mv_y[i], 31, 31,
                     mk($sformatf("body_move%0d", i), mv_x[i], mv_y[i], mv_len[i], 0, mv_col[i], 0, 0));
        end

        // Saturation: length stops at MAX_LEN on a non-self-intersecting path.
        do_reset("reset_before_sat");
        for (int k = 0; k < 40; k++) begin
            sat_len = (4 + k > 32) ? 32 : 4 + k;
            step(MAIN_GAME1, 1, 1, k % 32, 10 + k / 32, 31, 31,
                 mk($sformatf("sat%0d", k), k % 32, 10 + k / 32, sat_len, sat_len == 32, 0, 0, 0));
        end
        step(MAIN_GAME1, 0, 1, 0, 0, 31, 31, mk("sat_grow_only", 7, 11, 32, 1, 0, 0, 0));
        step(MAIN_GAME1, 1, 0, 8, 12, 31, 31, mk("sat_move_after", 8, 12, 32, 1, 0, 0, 0));

        do_reset("reset_mid_game");
        step(MAIN_WAIT, 0, 0, 0, 0, 6, 8, mk("after_reset_q_seg2", 8, 8, 3, 0, 0, 1, 0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
